// File: rtl/timer_bank_if.sv
// Configuration / status bundle for timer_bank.
// Master side (CPU / bench) drives configuration writes and acknowledges;
// slave side (timer_bank) returns tick pulses, sticky pending flags and run state.
interface timer_bank_if #(
   parameter int Channels  = 4,
   parameter int TimerBits = 32,
   parameter int ChBits    = (Channels > 1) ? $clog2(Channels) : 1
) ();
   logic                 cfg_we;
   logic [ChBits-1:0]    cfg_ch;
   logic [TimerBits-1:0] cfg_period;
   logic                 cfg_oneshot;
   logic                 cfg_enable;
   logic [Channels-1:0]  ack;
   logic [Channels-1:0]  tick;
   logic [Channels-1:0]  pending;
   logic [Channels-1:0]  running;

   modport master (
      output cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_enable, ack,
      input  tick, pending, running
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, cfg_enable, ack,
      output tick, pending, running
   );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable interval timer.
// Each channel counts steps up to period-1, then expires: a one-cycle tick,
// a sticky pending flag (cleared by ack) and, in one-shot mode, self-disable.
// Periods below 2 are clamped to 2.
// Optional feature macro: TIMER_BANK_PRESCALER_EN -- when defined, counters
// step only on a free-running prescaler strobe (every PrescaleDiv clocks).
// Handshake: cfg_we is a single-cycle strobe sampled on posedge clk, no ready;
// a write to cfg_ch >= Channels is dropped. ack is a per-channel level sampled
// every edge; tick/pending/running are registered outputs.
module timer_bank #(
   parameter int Channels    = 4,
   parameter int TimerBits   = 32,
   parameter int ChBits      = (Channels > 1) ? $clog2(Channels) : 1,
   parameter int PrescaleDiv = 4
) (
   input  logic         clk,
   input  logic         res,
   timer_bank_if.slave  bus
);

   // Elaboration-time guard on parameter ranges.
   if (Channels < 1 || Channels > 16 || PrescaleDiv < 1) begin : g_param_check
      $error("timer_bank: parameter out of range");
   end

   logic [TimerBits-1:0] cnt_q    [Channels];
   logic [TimerBits-1:0] cnt_d    [Channels];
   logic [TimerBits-1:0] period_q [Channels];
   logic [TimerBits-1:0] period_d [Channels];
   logic [Channels-1:0]  oneshot_q, oneshot_d;
   logic [Channels-1:0]  enable_q,  enable_d;
   logic [Channels-1:0]  tick_q,    tick_d;
   logic [Channels-1:0]  pending_q, pending_d;
   logic                 step;

`ifdef TIMER_BANK_PRESCALER_EN
   localparam int PW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
   logic [PW-1:0] presc_q, presc_d;

   // Free-running prescaler; only reset clears it, config writes do not.
   always_comb begin
      step    = (presc_q == PW'(PrescaleDiv - 1));
      presc_d = step ? '0 : presc_q + PW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (res) presc_q <= '0;
      else     presc_q <= presc_d;
   end
`else
   assign step = 1'b1;
`endif

   // Per-channel next state: stepping, expiry, acknowledge, then config
   // write last so that a write on the expiry cycle overrides the expiry.
   always_comb begin
      logic expire;
      logic hit;
      tick_d    = '0;
      oneshot_d = oneshot_q;
      enable_d  = enable_q;
      pending_d = pending_q;
      expire    = 1'b0;
      hit       = 1'b0;
      for (int ch = 0; ch < Channels; ch++) begin
         cnt_d[ch]    = cnt_q[ch];
         period_d[ch] = period_q[ch];
         expire = step && enable_q[ch] &&
                  (cnt_q[ch] == period_q[ch] - TimerBits'(1));
         hit    = bus.cfg_we && (bus.cfg_ch == ChBits'(ch));

         if (expire) begin
            cnt_d[ch]     = '0;
            tick_d[ch]    = 1'b1;
            pending_d[ch] = 1'b1;
            if (oneshot_q[ch]) enable_d[ch] = 1'b0;
         end else begin
            if (step && enable_q[ch]) cnt_d[ch] = cnt_q[ch] + TimerBits'(1);
            if (bus.ack[ch]) pending_d[ch] = 1'b0;
         end

         if (hit) begin
            period_d[ch]  = (bus.cfg_period < TimerBits'(2)) ? TimerBits'(2)
                                                              : bus.cfg_period;
            oneshot_d[ch] = bus.cfg_oneshot;
            enable_d[ch]  = bus.cfg_enable;
            cnt_d[ch]     = '0;
            tick_d[ch]    = 1'b0;
            pending_d[ch] = bus.ack[ch] ? 1'b0 : pending_q[ch];
         end
      end
   end

   // Channel state registers; reset discards all progress.
   always_ff @(posedge clk) begin
      if (res) begin
         for (int ch = 0; ch < Channels; ch++) begin
            cnt_q[ch]    <= '0;
            period_q[ch] <= TimerBits'(2);
         end
         oneshot_q <= '0;
         enable_q  <= '0;
         tick_q    <= '0;
         pending_q <= '0;
      end else begin
         for (int ch = 0; ch < Channels; ch++) begin
            cnt_q[ch]    <= cnt_d[ch];
            period_q[ch] <= period_d[ch];
         end
         oneshot_q <= oneshot_d;
         enable_q  <= enable_d;
         tick_q    <= tick_d;
         pending_q <= pending_d;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.pending = pending_q;
   assign bus.running = enable_q;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed vector table, hand-written corner sequences,
// then randomized traffic against a countdown reference model.
module tb_timer_bank;
   localparam int CH  = 5;
   localparam int TB  = 32;
   localparam int CHB = 3;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic res;
   int   n_checks = 0;
   int   n_errors = 0;

   timer_bank_if #(.Channels(CH), .TimerBits(TB), .ChBits(CHB)) bus ();

   timer_bank #(.Channels(CH), .TimerBits(TB), .ChBits(CHB), .PrescaleDiv(DIV)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Each channel tracks the number of steps left until its next expiry.
   int               m_rem [CH];
   int               m_per [CH];
   bit               m_en  [CH];
   bit               m_os  [CH];
   logic [CH-1:0]    m_tick, m_pend;
   int               m_presc;
   logic [3*CH-1:0]  exp_q[$];

   task automatic model_step(input logic r, input logic we, input logic [CHB-1:0] ch,
                             input logic [TB-1:0] per, input logic os, input logic en,
                             input logic [CH-1:0] ak);
      bit stp, hit, expd;
      logic [CH-1:0] run;
      if (r) begin
         for (int c = 0; c < CH; c++) begin
            m_per[c] = 2; m_rem[c] = 2; m_en[c] = 0; m_os[c] = 0;
         end
         m_tick = '0; m_pend = '0; m_presc = 0;
      end else begin
`ifdef TIMER_BANK_PRESCALER_EN
         stp = (m_presc == DIV - 1);
         m_presc = stp ? 0 : m_presc + 1;
`else
         stp = 1'b1;
`endif
         for (int c = 0; c < CH; c++) begin
            hit  = we && (int'(ch) == c);
            expd = stp && m_en[c] && (m_rem[c] == 1);
            m_tick[c] = 1'b0;
            if (hit) begin
               m_per[c] = (per < 2) ? 2 : int'(per);
               m_rem[c] = m_per[c];
               m_en[c]  = en;
               m_os[c]  = os;
               if (ak[c]) m_pend[c] = 1'b0;
            end else if (expd) begin
               m_tick[c] = 1'b1;
               m_pend[c] = 1'b1;
               m_rem[c]  = m_per[c];
               if (m_os[c]) m_en[c] = 0;
            end else begin
               if (stp && m_en[c]) m_rem[c] = m_rem[c] - 1;
               if (ak[c]) m_pend[c] = 1'b0;
            end
         end
      end
      for (int c = 0; c < CH; c++) run[c] = m_en[c];
      exp_q.push_back({m_tick, m_pend, run});
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic sb_check();
      logic [3*CH-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL sb_empty @%0t: got no expectation expected one", $time);
      end else begin
         n_checks--;
         e = exp_q.pop_front();
         check("model_tick",    bus.tick,    e[3*CH-1:2*CH]);
         check("model_pending", bus.pending, e[2*CH-1:CH]);
         check("model_running", bus.running, e[CH-1:0]);
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change on negedge, DUT samples on posedge, outputs checked 1 time unit later.
   task automatic drive_cycle(input logic r, input logic we, input logic [CHB-1:0] ch,
                              input logic [TB-1:0] per, input logic os, input logic en,
                              input logic [CH-1:0] ak);
      @(negedge clk);
      res             = r;
      bus.cfg_we      = we;
      bus.cfg_ch      = ch;
      bus.cfg_period  = per;
      bus.cfg_oneshot = os;
      bus.cfg_enable  = en;
      bus.ack         = ak;
      @(posedge clk);
      model_step(r, we, ch, per, os, en, ak);
      #1;
      sb_check();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic write(input logic [CHB-1:0] ch, input logic [TB-1:0] per,
                        input logic os, input logic en);
      drive_cycle(1'b0, 1'b1, ch, per, os, en, '0);
   endtask

   task automatic do_reset();
      drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic            r;
      logic            we;
      logic [CHB-1:0]  ch;
      logic [TB-1:0]   per;
      logic            os;
      logic            en;
      logic [CH-1:0]   ak;
      logic [CH-1:0]   t;
      logic [CH-1:0]   p;
      logic [CH-1:0]   run;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int last_tick;
      res = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
      bus.cfg_oneshot = 1'b0; bus.cfg_enable = 1'b0; bus.ack = '0;

`ifndef TIMER_BANK_PRESCALER_EN
      // Reset held 3 cycles with a pending write, then periodic ch0 (P=5),
      // one-shot ch1 (P=3) overlaid, then ack of both.
      for (int i = 0; i < 3; i++)
         tbl.push_back('{1'b1, 1'b1, 3'd0, 32'd5, 1'b0, 1'b1, 5'b0, 5'b0, 5'b0, 5'b0});
      tbl.push_back('{1'b0, 1'b1, 3'd0, 32'd5, 1'b0, 1'b1, 5'b0, 5'b0, 5'b0, 5'b00001});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b0, 5'b0, 5'b00001});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b00001, 5'b00001, 5'b00001});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b0, 5'b00001, 5'b00001});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b00001, 5'b00001, 5'b00001});
      tbl.push_back('{1'b0, 1'b1, 3'd1, 32'd3, 1'b1, 1'b1, 5'b0, 5'b0, 5'b00001, 5'b00011});
      for (int i = 0; i < 2; i++)
         tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b0, 5'b00001, 5'b00011});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b00010, 5'b00011, 5'b00001});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b00001, 5'b00011, 5'b00001});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b0, 5'b0, 5'b00011, 5'b00001});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 5'b00011, 5'b0, 5'b0, 5'b00001});

      foreach (tbl[i]) begin
         drive_cycle(tbl[i].r, tbl[i].we, tbl[i].ch, tbl[i].per, tbl[i].os, tbl[i].en, tbl[i].ak);
         check($sformatf("tbl%0d_tick", i),    bus.tick,    tbl[i].t);
         check($sformatf("tbl%0d_pending", i), bus.pending, tbl[i].p);
         check($sformatf("tbl%0d_running", i), bus.running, tbl[i].run);
      end
      idle(20);

      // Clamp and ack: period 0 runs as period 2.
      do_reset();
      write(3'd2, 32'd0, 1'b0, 1'b1);
      idle(1);
      check("clamp_no_tick_early", bus.tick & 5'b00100, 5'b00000);
      idle(1);
      check("clamp_tick", bus.tick & 5'b00100, 5'b00100);
      idle(1);
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 5'b00100);
      check("ack_on_expiry_keeps", bus.pending & 5'b00100, 5'b00100);
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 5'b00100);
      check("ack_clears", bus.pending & 5'b00100, 5'b00000);
      idle(4);

      // Write colliding with expiry, then out-of-range writes.
      do_reset();
      write(3'd0, 32'd4, 1'b0, 1'b1);
      idle(3);
      write(3'd0, 32'd4, 1'b0, 1'b1);
      check("collide_no_tick", bus.tick & 5'b00001, 5'b00000);
      check("collide_no_pending", bus.pending & 5'b00001, 5'b00000);
      idle(3);
      check("collide_restart_quiet", bus.tick & 5'b00001, 5'b00000);
      idle(1);
      check("collide_restart_tick", bus.tick & 5'b00001, 5'b00001);
      write(3'd5, 32'd2, 1'b0, 1'b1);
      check("oob_write5", bus.running, 5'b00001);
      write(3'd7, 32'd2, 1'b1, 1'b0);
      check("oob_write7", bus.running, 5'b00001);
      idle(6);
`else
      // Prescaled: ch3 period 2 ticks every 2*DIV clocks, one cycle wide.
      do_reset();
      write(3'd3, 32'd2, 1'b0, 1'b1);
      last_tick = -1;
      for (int i = 0; i < 40; i++) begin
         idle(1);
         if (bus.tick[3]) begin
            if (last_tick >= 0) begin
               n_checks++;
               if (i - last_tick != 2 * DIV) begin
                  n_errors++;
                  $display("FAIL presc_interval: got %0d expected %0d", i - last_tick, 2 * DIV);
               end
            end
            last_tick = i;
         end
      end
      check("presc_saw_tick", {4'b0, last_tick >= 0}, 5'b00001);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic r, we, os, en;
         logic [CHB-1:0] ch;
         logic [TB-1:0] per;
         logic [CH-1:0] ak;
         r  = ($urandom_range(0, 149) == 0);
         we = ($urandom_range(0, 4) == 0);
         ch = CHB'($urandom_range(0, 7));
         per = TB'($urandom_range(0, 9));
         os = $urandom_range(0, 1);
         en = ($urandom_range(0, 5) != 0);
         ak = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
         drive_cycle(r, we, ch, per, os, en, ak);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
